hv_cmdq_mc: RTL and testbench

HV_CMDQ_MC -- requirements
Module: hv_cmdq_mc

---
 rtl/hv_cmdq_pkg.sv | 24 ++
 rtl/hv_cdb_cksum.sv | 28 ++
 rtl/hv_cmdq_mc.sv | 182 ++++++++++++++++++
 tb/tb_hv_cmdq_mc.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hv_cmdq_pkg.sv
// Shared types for the command queue: slot lifecycle, dispatch FSM and completion codes.
package hv_cmdq_pkg;

  typedef enum logic [2:0] {
    SLOT_FREE,
    SLOT_LOAD,
    SLOT_READY,
    SLOT_CKS_ERR,
    SLOT_ISSUED,
    SLOT_DONE,
    SLOT_FAILED
  } slot_state_e;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_SCAN,
    DS_XFER
  } disp_state_e;

  localparam logic [1:0] CMPL_OK       = 2'd0;
  localparam logic [1:0] CMPL_PROC_ERR = 2'd1;
  localparam logic [1:0] CMPL_CKS_ERR  = 2'd2;

endpackage

// File: rtl/hv_cdb_cksum.sv
// Running 32-bit XOR over the words of each incoming CDB beat; accumulator restarts on the first beat.
module hv_cdb_cksum #(
  parameter int unsigned IO_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            beat_en,
  input  logic            first,
  input  logic [IO_W-1:0] data,
  output logic [31:0]     cksum_c
);
  localparam int unsigned WORDS = IO_W / 32;

  logic [31:0] acc_q;
  logic [31:0] fold;

  always_comb begin
    fold = '0;
    for (int i = 0; i < int'(WORDS); i++) fold = fold ^ data[i*32 +: 32];
    cksum_c = (first ? 32'd0 : acc_q) ^ fold;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else if (beat_en) acc_q <= cksum_c;
  end

endmodule

// File: rtl/hv_cmdq_mc.sv
// Command queue: loads multi-beat CDBs, verifies their checksum, dispatches them in order
// and retires completions strictly in order.
module hv_cmdq_mc
  import hv_cmdq_pkg::*;
#(
  parameter int unsigned IO_W   = 64,
  parameter int unsigned CDB_W  = 256,
  parameter int unsigned QD_BIT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cin_valid,
  output logic              cin_ready,
  input  logic [IO_W-1:0]   cin_data,
  input  logic              cout_req,
  output logic              cout_valid,
  output logic              cout_last,
  output logic [QD_BIT-1:0] cout_tag,
  output logic [IO_W-1:0]   cout_data,
  input  logic              st_we,
  input  logic [QD_BIT-1:0] st_tag,
  input  logic              st_err,
  output logic              cmpl_valid,
  input  logic              cmpl_ready,
  output logic [QD_BIT-1:0] cmpl_tag,
  output logic [1:0]        cmpl_code,
  output logic [QD_BIT:0]   q_count
);
  localparam int unsigned BEATS = CDB_W / IO_W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEPTH = 2 ** QD_BIT;
  localparam int unsigned PW    = QD_BIT + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  slot_state_e     slot_q [DEPTH];
  logic [IO_W-1:0] mem_q  [DEPTH][BEATS];

  logic [PW-1:0]     head_q, issue_q, tail_q, head_d, issue_d, tail_d;
  logic [BW-1:0]     ld_beat_q, xb_q, xb_d;
  disp_state_e       state_q, state_d;
  logic [31:0]       cksum_c;
  logic              accept, ld_last, retire, xfer_done, st_hit;
  logic              cout_valid_d, cout_last_d, cmpl_valid_d, full_d;
  logic [QD_BIT-1:0] cout_tag_d, tail_idx_d;
  logic [IO_W-1:0]   cout_data_d;
  logic [1:0]        cmpl_code_d;

  assign accept  = cin_valid && cin_ready;
  assign ld_last = (ld_beat_q == LAST_BEAT);
  assign retire  = cmpl_valid && cmpl_ready;
  assign st_hit  = st_we && (slot_q[st_tag] == SLOT_ISSUED);

  hv_cdb_cksum #(.IO_W(IO_W)) u_cksum (
    .clk     (clk),
    .reset   (reset),
    .beat_en (accept),
    .first   (ld_beat_q == '0),
    .data    (cin_data),
    .cksum_c (cksum_c)
  );

  // Load and retire pointers; head only moves once a whole CDB has landed.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (accept && ld_last) head_d = head_q + PW'(1);
    if (retire)            tail_d = tail_q + PW'(1);
    full_d = (head_d[QD_BIT] != tail_d[QD_BIT]) &&
             (head_d[QD_BIT-1:0] == tail_d[QD_BIT-1:0]);
  end

  // Dispatch FSM next state; beat outputs are decoded from the next state so they register in step.
  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    xb_d      = xb_q;
    xfer_done = 1'b0;
    unique case (state_q)
      DS_IDLE: if (cout_req && (issue_q != head_q)) state_d = DS_SCAN;
      DS_SCAN: begin
        if (issue_q == head_q) begin
          state_d = DS_IDLE;
        end else if (slot_q[issue_q[QD_BIT-1:0]] == SLOT_READY) begin
          state_d = DS_XFER;
          xb_d    = '0;
        end else if (slot_q[issue_q[QD_BIT-1:0]] == SLOT_CKS_ERR) begin
          issue_d = issue_q + PW'(1);
        end
      end
      DS_XFER: begin
        if (xb_q == LAST_BEAT) begin
          state_d   = DS_IDLE;
          issue_d   = issue_q + PW'(1);
          xb_d      = '0;
          xfer_done = 1'b1;
        end else begin
          xb_d = xb_q + BW'(1);
        end
      end
      default: state_d = DS_IDLE;
    endcase
    cout_valid_d = (state_d == DS_XFER);
    cout_last_d  = cout_valid_d && (xb_d == LAST_BEAT);
    cout_tag_d   = cout_valid_d ? issue_d[QD_BIT-1:0] : '0;
    cout_data_d  = cout_valid_d ? mem_q[issue_d[QD_BIT-1:0]][xb_d] : '0;
  end

  // Retirement lookahead: the slot at the next tail, including a completion landing this cycle.
  always_comb begin
    cmpl_valid_d = 1'b0;
    cmpl_code_d  = CMPL_OK;
    tail_idx_d   = tail_d[QD_BIT-1:0];
    if (tail_d != issue_d) begin
      if (st_hit && (st_tag == tail_idx_d)) begin
        cmpl_valid_d = 1'b1;
        cmpl_code_d  = st_err ? CMPL_PROC_ERR : CMPL_OK;
      end else begin
        case (slot_q[tail_idx_d])
          SLOT_DONE:    begin cmpl_valid_d = 1'b1; cmpl_code_d = CMPL_OK;       end
          SLOT_FAILED:  begin cmpl_valid_d = 1'b1; cmpl_code_d = CMPL_PROC_ERR; end
          SLOT_CKS_ERR: begin cmpl_valid_d = 1'b1; cmpl_code_d = CMPL_CKS_ERR;  end
          default:      cmpl_valid_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= DS_IDLE;
      head_q     <= '0;
      issue_q    <= '0;
      tail_q     <= '0;
      ld_beat_q  <= '0;
      xb_q       <= '0;
      cin_ready  <= 1'b1;
      q_count    <= '0;
      cout_valid <= 1'b0;
      cout_last  <= 1'b0;
      cout_tag   <= '0;
      cout_data  <= '0;
      cmpl_valid <= 1'b0;
      cmpl_tag   <= '0;
      cmpl_code  <= CMPL_OK;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      issue_q    <= issue_d;
      tail_q     <= tail_d;
      xb_q       <= xb_d;
      if (accept) ld_beat_q <= ld_last ? '0 : ld_beat_q + BW'(1);
      cin_ready  <= !full_d;
      q_count    <= head_d - tail_d;
      cout_valid <= cout_valid_d;
      cout_last  <= cout_last_d;
      cout_tag   <= cout_tag_d;
      cout_data  <= cout_data_d;
      cmpl_valid <= cmpl_valid_d;
      cmpl_tag   <= tail_idx_d;
      cmpl_code  <= cmpl_code_d;
    end
  end

  // Slot lifecycle; the four writers never target the same slot in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= SLOT_FREE;
    end else begin
      if (accept)
        slot_q[head_q[QD_BIT-1:0]] <= !ld_last ? SLOT_LOAD :
                                      (cksum_c == 32'd0) ? SLOT_READY : SLOT_CKS_ERR;
      if (xfer_done) slot_q[issue_q[QD_BIT-1:0]] <= SLOT_ISSUED;
      if (st_hit)    slot_q[st_tag] <= st_err ? SLOT_FAILED : SLOT_DONE;
      if (retire)    slot_q[tail_q[QD_BIT-1:0]] <= SLOT_FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[head_q[QD_BIT-1:0]][ld_beat_q] <= cin_data;
  end

endmodule

// File: tb/tb_hv_cmdq_mc.sv
// Randomized bench for hv_cmdq_mc against a transaction-level queue model.
module tb_hv_cmdq_mc;
  localparam int IO_W   = 64;
  localparam int CDB_W  = 256;
  localparam int QD_BIT = 5;
  localparam int BEATS  = CDB_W / IO_W;
  localparam int DEPTH  = 2 ** QD_BIT;

  localparam int M_FREE = 0, M_READY = 1, M_CKS = 2, M_ISSUED = 3, M_DONE = 4, M_FAILED = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              cin_valid, cin_ready;
  logic [IO_W-1:0]   cin_data;
  logic              cout_req, cout_valid, cout_last;
  logic [QD_BIT-1:0] cout_tag;
  logic [IO_W-1:0]   cout_data;
  logic              st_we, st_err;
  logic [QD_BIT-1:0] st_tag;
  logic              cmpl_valid, cmpl_ready;
  logic [QD_BIT-1:0] cmpl_tag;
  logic [1:0]        cmpl_code;
  logic [QD_BIT:0]   q_count;

  int n_checks = 0;
  int n_pass   = 0;

  int              m_st   [DEPTH];
  logic [IO_W-1:0] m_data [DEPTH][BEATS];
  int              m_head, m_issue, m_tail;

  always #5 clk = ~clk;

  hv_cmdq_mc #(.IO_W(IO_W), .CDB_W(CDB_W), .QD_BIT(QD_BIT)) dut (
    .clk(clk), .reset(reset),
    .cin_valid(cin_valid), .cin_ready(cin_ready), .cin_data(cin_data),
    .cout_req(cout_req), .cout_valid(cout_valid), .cout_last(cout_last),
    .cout_tag(cout_tag), .cout_data(cout_data),
    .st_we(st_we), .st_tag(st_tag), .st_err(st_err),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
    .cmpl_tag(cmpl_tag), .cmpl_code(cmpl_code), .q_count(q_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cdb_xor(input logic [CDB_W-1:0] c);
    logic [31:0] x = '0;
    for (int w = 0; w < CDB_W / 32; w++) x = x ^ c[w*32 +: 32];
    return x;
  endfunction

  function automatic logic [CDB_W-1:0] make_cdb(input bit good);
    logic [CDB_W-1:0] c;
    logic [31:0]      x;
    for (int w = 0; w < CDB_W / 32; w++) c[w*32 +: 32] = $urandom();
    x = cdb_xor(c);
    if (good) c[31:0] = c[31:0] ^ x;
    else if (x == 32'd0) c[0] = ~c[0];
    return c;
  endfunction

  function automatic bit front_elig();
    int s;
    if (m_tail == m_head) return 1'b0;
    s = m_st[m_tail % DEPTH];
    return (s == M_DONE) || (s == M_FAILED) || (s == M_CKS && m_issue > m_tail);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_st[i] = M_FREE;
    m_head = 0; m_issue = 0; m_tail = 0;
  endtask

  task automatic apply_reset();
    cin_valid = 0; cin_data = '0; cout_req = 0; st_we = 0; st_tag = '0; st_err = 0; cmpl_ready = 0;
    reset = 0;
    tick(); tick();
    reset = 1;
    model_clear();
  endtask

  task automatic check_occupancy(input string tag);
    chk({tag, "_q_count"}, 64'(q_count), 64'(m_head - m_tail));
    chk({tag, "_cin_ready"}, 64'(cin_ready), 64'((m_head - m_tail) < DEPTH));
  endtask

  task automatic load_cdb(input logic [CDB_W-1:0] c);
    int tg;
    chk("load_cin_ready_pre", 64'(cin_ready), 64'(1));
    for (int b = 0; b < BEATS; b++) begin
      cin_valid = 1;
      cin_data  = c[b*IO_W +: IO_W];
      tick();
    end
    cin_valid = 0;
    cin_data  = '0;
    tg = m_head % DEPTH;
    for (int b = 0; b < BEATS; b++) m_data[tg][b] = c[b*IO_W +: IO_W];
    m_st[tg] = (cdb_xor(c) == 32'd0) ? M_READY : M_CKS;
    m_head++;
    check_occupancy("load");
  endtask

  task automatic dispatch();
    int p, tg, guard, nstray;
    p = m_issue;
    while (p < m_head && m_st[p % DEPTH] == M_CKS) p++;
    cout_req = 1;
    tick();
    cout_req = 0;
    if (p < m_head) begin
      tg = p % DEPTH;
      guard = 0;
      while (!cout_valid && guard < 2 * DEPTH + 4) begin
        tick();
        guard++;
      end
      for (int b = 0; b < BEATS; b++) begin
        chk("cout_valid", 64'(cout_valid), 64'(1));
        chk("cout_tag", 64'(cout_tag), 64'(tg));
        chk("cout_data", cout_data, m_data[tg][b]);
        chk("cout_last", 64'(cout_last), 64'(b == BEATS - 1));
        tick();
      end
      chk("cout_idle_after", 64'(cout_valid), 64'(0));
      m_st[tg] = M_ISSUED;
      m_issue  = p + 1;
    end else begin
      nstray = 0;
      repeat (2 * DEPTH + 4) begin
        if (cout_valid) nstray++;
        tick();
      end
      chk("cout_no_ready_slot", 64'(nstray), 64'(0));
      m_issue = m_head;
    end
  endtask

  task automatic status(input int tg, input bit err);
    st_we = 1; st_tag = QD_BIT'(tg); st_err = err;
    tick();
    st_we = 0; st_err = 0;
    if (m_st[tg] == M_ISSUED) m_st[tg] = err ? M_FAILED : M_DONE;
  endtask

  task automatic retire_check();
    bit el;
    int ft, code;
    el = front_elig();
    chk("cmpl_valid", 64'(cmpl_valid), 64'(el));
    if (el) begin
      ft = m_tail % DEPTH;
      code = (m_st[ft] == M_DONE) ? 0 : (m_st[ft] == M_FAILED) ? 1 : 2;
      chk("cmpl_tag", 64'(cmpl_tag), 64'(ft));
      chk("cmpl_code", 64'(cmpl_code), 64'(code));
      tick();
      chk("cmpl_hold_valid", 64'(cmpl_valid), 64'(1));
      chk("cmpl_hold_tag", 64'(cmpl_tag), 64'(ft));
      chk("cmpl_hold_code", 64'(cmpl_code), 64'(code));
      cmpl_ready = 1;
      tick();
      cmpl_ready = 0;
      m_st[ft] = M_FREE;
      m_tail++;
      check_occupancy("retire");
    end
  endtask

  task automatic rand_status();
    int cand[$];
    int tg;
    for (int p = m_tail; p < m_head; p++)
      if (m_st[p % DEPTH] == M_ISSUED) cand.push_back(p % DEPTH);
    if (cand.size() == 0 || $urandom_range(0, 3) == 0) tg = $urandom_range(0, DEPTH - 1);
    else tg = cand[$urandom_range(0, cand.size() - 1)];
    status(tg, 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int ft;
    for (int g = 0; g < 400 && m_tail < m_head; g++) begin
      ft = m_tail % DEPTH;
      if (front_elig()) retire_check();
      else if (m_st[ft] == M_ISSUED) status(ft, 1'($urandom_range(0, 1)));
      else dispatch();
    end
    chk("drain_empty", 64'(q_count), 64'(0));
  endtask

  initial begin
    logic [CDB_W-1:0] c;
    int guard, nstray, op;

    // Reset values while reset is held low.
    cin_valid = 0; cin_data = '0; cout_req = 0; st_we = 0; st_tag = '0; st_err = 0; cmpl_ready = 0;
    reset = 0;
    tick(); tick();
    chk("rst_cin_ready", 64'(cin_ready), 64'(1));
    chk("rst_cout_valid", 64'(cout_valid), 64'(0));
    chk("rst_cout_last", 64'(cout_last), 64'(0));
    chk("rst_cout_tag", 64'(cout_tag), 64'(0));
    chk("rst_cout_data", cout_data, 64'(0));
    chk("rst_cmpl_valid", 64'(cmpl_valid), 64'(0));
    chk("rst_q_count", 64'(q_count), 64'(0));
    reset = 1;
    model_clear();

    // Single good CDB through dispatch, completion and retirement.
    load_cdb(make_cdb(1));
    dispatch();
    status(0, 0);
    retire_check();

    // Checksum-error CDB is skipped by dispatch and retires with code 2.
    apply_reset();
    c = '0;
    c[31:0] = 32'd1;
    load_cdb(c);
    load_cdb(make_cdb(1));
    dispatch();
    retire_check();
    status(1, 0);
    retire_check();

    // Out-of-order completions retire in order.
    apply_reset();
    repeat (3) load_cdb(make_cdb(1));
    repeat (3) dispatch();
    status(2, 0);
    status(0, 1);
    retire_check();
    retire_check();
    status(1, 0);
    retire_check();
    retire_check();

    // Full queue: a beat offered in the retire cycle waits one cycle.
    apply_reset();
    load_cdb(make_cdb(0));
    repeat (DEPTH - 1) load_cdb(make_cdb(1));
    check_occupancy("full");
    dispatch();
    c = make_cdb(1);
    chk("full_cmpl_valid", 64'(cmpl_valid), 64'(1));
    cin_valid = 1; cin_data = c[IO_W-1:0]; cmpl_ready = 1;
    tick();
    cin_valid = 0; cmpl_ready = 0;
    m_st[0] = M_FREE;
    m_tail++;
    check_occupancy("full_retire");
    load_cdb(c);
    drain();

    // Reset mid-load discards the partial CDB.
    apply_reset();
    c = make_cdb(1);
    cin_valid = 1; cin_data = c[IO_W-1:0];
    tick();
    cin_data = c[2*IO_W-1:IO_W];
    tick();
    cin_valid = 0;
    reset = 0;
    tick();
    reset = 1;
    model_clear();
    chk("midload_q_count", 64'(q_count), 64'(0));
    load_cdb(make_cdb(1));
    dispatch();

    // Reset during the second beat of a transfer.
    load_cdb(make_cdb(1));
    cout_req = 1;
    tick();
    cout_req = 0;
    guard = 0;
    while (!cout_valid && guard < 10) begin
      tick();
      guard++;
    end
    tick();
    chk("xfer_beat2_valid", 64'(cout_valid), 64'(1));
    reset = 0;
    tick();
    chk("xfer_rst_cout_valid", 64'(cout_valid), 64'(0));
    chk("xfer_rst_q_count", 64'(q_count), 64'(0));
    chk("xfer_rst_cin_ready", 64'(cin_ready), 64'(1));
    reset = 1;
    model_clear();
    nstray = 0;
    repeat (8) begin
      tick();
      if (cout_valid) nstray++;
    end
    chk("xfer_rst_no_stray", 64'(nstray), 64'(0));

    // Randomized mix of loads, dispatches, completions and retirements.
    for (int i = 0; i < 160; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        if ((m_head - m_tail) < DEPTH) load_cdb(make_cdb($urandom_range(0, 3) != 0));
      end else if (op <= 5) begin
        dispatch();
      end else if (op <= 7) begin
        rand_status();
      end else begin
        retire_check();
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
